// File: rtl/pkg_detect_pkg.sv
// Shared types, error codes and marker helpers for the packet framer.
package pkg_detect_pkg;

   typedef enum logic [1:0] {IDLE, PAYLOAD, DONE, ERR} state_t;

   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_SHORT = 2'd1;
   localparam logic [1:0] ERR_OVF   = 2'd2;
   localparam logic [1:0] ERR_TMO   = 2'd3;

   // Markers are built wide and truncated to the 2*width bus by the caller.
   localparam int MARKER_W = 128;

   // Largest positive value of a signed 2*width bus: 0 followed by all ones.
   function automatic logic [MARKER_W-1:0] sof_marker(input int width);
      return (MARKER_W'(1) << (2 * width - 1)) - MARKER_W'(1);
   endfunction

   // Most negative value of a signed 2*width bus: 1 followed by all zeros.
   function automatic logic [MARKER_W-1:0] eof_marker(input int width);
      return MARKER_W'(1) << (2 * width - 1);
   endfunction

endpackage

// File: rtl/pkg_detect_param_watchdog.sv
// Idle-cycle watchdog: counts enabled cycles, pulses term on the TIMEOUT-1 count.
// Clear has priority over enable; the count stops at the terminal value.
module pkg_watchdog #(
   parameter int TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic term
);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

   logic [TW-1:0] cnt;

   assign term = en && (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en && !term)
         cnt <= cnt + TW'(1);
   end
endmodule

// File: rtl/pkg_detect_param.sv
// Frames the demodulator stream between SOF/EOF markers, counts payload and flags short/overflow frames.
// Build option PKG_DETECT_TIMEOUT_EN adds the idle watchdog abort (error code 3).
module pkg_detect_param
   import pkg_detect_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int MIN_LEN = 4,
   parameter int MAX_LEN = 256,
   parameter int TIMEOUT = 1024,
   parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   input  logic signed [2*WIDTH-1:0] data_i,
   output logic                      start_o,
   output logic signed [2*WIDTH-1:0] payload_o,
   output logic                      payload_valid_o,
   output logic                      valid_o,
   output logic [LEN_W-1:0]          len_o,
   output logic                      err_o,
   output logic [1:0]                err_code_o
);
   localparam int DW = 2 * WIDTH;
   localparam logic [DW-1:0]    SOF  = DW'(sof_marker(WIDTH));
   localparam logic [DW-1:0]    EOF  = DW'(eof_marker(WIDTH));
   localparam logic [LEN_W-1:0] MINL = LEN_W'(MIN_LEN);
   localparam logic [LEN_W-1:0] MAXL = LEN_W'(MAX_LEN);

   logic signed [DW-1:0] data_r;
   logic                 valid_r;
   state_t               state, state_nxt;
   logic [LEN_W-1:0]     cnt, cnt_nxt, len_nxt;
   logic [1:0]           code_nxt;
   logic                 is_sof, is_eof, fwd;

   assign is_sof = valid_r && (data_r == SOF);
   assign is_eof = valid_r && (data_r == EOF);

`ifdef PKG_DETECT_TIMEOUT_EN
   logic wd_clr, wd_en, wd_term;

   // Any accepted word, or being outside PAYLOAD, restarts the idle count.
   assign wd_clr = (state != PAYLOAD) || valid_r;
   assign wd_en  = (state == PAYLOAD) && !valid_r;

   pkg_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (wd_clr),
      .en    (wd_en),
      .term  (wd_term)
   );
`else
   logic unused_tmo;
   assign unused_tmo = (TIMEOUT != 0);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_r     <= '0;
         valid_r    <= 1'b0;
         state      <= IDLE;
         cnt        <= '0;
         len_o      <= '0;
         err_code_o <= ERR_NONE;
      end else begin
         data_r     <= data_i;
         valid_r    <= in_valid;
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         len_o      <= len_nxt;
         err_code_o <= code_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      len_nxt   = len_o;
      code_nxt  = err_code_o;
      fwd       = 1'b0;
      case (state)
         IDLE: begin
            if (is_sof) begin
               state_nxt = PAYLOAD;
               cnt_nxt   = '0;
               code_nxt  = ERR_NONE;
            end
         end
         PAYLOAD: begin
            if (is_sof) begin
               cnt_nxt = '0;
            end else if (is_eof) begin
               len_nxt = cnt;
               if (cnt >= MINL) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = ERR;
                  code_nxt  = ERR_SHORT;
               end
            end else if (valid_r && (cnt == MAXL)) begin
               // Overflowing word is dropped; cnt stays saturated at MAX_LEN.
               len_nxt   = cnt;
               state_nxt = ERR;
               code_nxt  = ERR_OVF;
            end else if (valid_r) begin
               fwd     = 1'b1;
               cnt_nxt = cnt + LEN_W'(1);
            end
`ifdef PKG_DETECT_TIMEOUT_EN
            else if (wd_term) begin
               len_nxt   = cnt;
               state_nxt = ERR;
               code_nxt  = ERR_TMO;
            end
`endif
         end
         DONE:    state_nxt = IDLE;
         ERR:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign start_o         = (state == PAYLOAD);
   assign valid_o         = (state == DONE);
   assign err_o           = (state == ERR);
   assign payload_o       = data_r;
   assign payload_valid_o = fwd;
endmodule

// File: doc/pkg_detect_param.md
Name: pkg_detect_param

Overview:
Parametrised successor packet framer for the FM demodulator output stream.
- Detects a start-of-frame (SOF) marker and an end-of-frame (EOF) marker in the 2*WIDTH-bit demodulated sample stream.
- Forwards payload samples between the markers, counts them, and reports the frame length on completion.
- Flags short, overflowing and timed-out frames.
- Sits between the demodulator output and the downstream packet buffer; adds an input-valid qualifier and length/error reporting.

Parameters:
WIDTH, 16, half sample width; the data bus is 2*WIDTH bits, signed.
MIN_LEN, 4, minimum payload samples for a good frame.
MAX_LEN, 256, maximum payload samples; a further payload sample is an overflow.
TIMEOUT, 1024, maximum consecutive cycles without in_valid while in PAYLOAD.
LEN_W, $clog2(MAX_LEN+1), width of the length counter and len_o.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
in_valid  in  1  data_i qualifier; a sample is accepted on each clk edge with in_valid=1.
data_i  in  2*WIDTH  signed demodulated sample.
start_o  out  1  high while inside a frame (state PAYLOAD).
payload_o  out  2*WIDTH  forwarded payload sample (registered input copy).
payload_valid_o  out  1  payload_o holds a counted payload sample this cycle.
valid_o  out  1  one-cycle pulse: good frame completed.
len_o  out  LEN_W  payload count of the last completed or aborted frame.
err_o  out  1  one-cycle pulse: frame aborted.
err_code_o  out  2  0 none, 1 short, 2 overflow, 3 timeout.

Behaviour:
- Reset (async, rst_n=0):
  - data_r=0, valid_r=0, state=IDLE, cnt=0, wdog=0.
  - All outputs 0; len_o=0; err_code_o=0.
- Input stage: data_r<=data_i and valid_r<=in_valid every edge; data_r is only interpreted when valid_r=1.
- Markers, derived from WIDTH:
  - SOF = max positive value: 0 followed by all ones.
  - EOF = min negative value: 1 followed by all zeros.
- States:
  - IDLE: valid_r and data_r==SOF -> PAYLOAD; cnt<=0; wdog<=0; err_code_o<=0.
  - PAYLOAD: evaluated in priority order:
    1. valid_r and data_r==SOF -> resync: cnt<=0, stay in PAYLOAD, nothing forwarded, no error.
    2. valid_r and data_r==EOF -> DONE if cnt>=MIN_LEN, else ERR with code 1.
    3. valid_r, non-marker, and cnt==MAX_LEN -> ERR with code 2; the word is not forwarded.
    4. valid_r, non-marker otherwise -> payload_valid_o=1, cnt<=cnt+1.
    5. valid_r=0 -> wdog<=wdog+1; when wdog reaches TIMEOUT-1 -> ERR with code 3.
    - Any valid_r=1 clears wdog.
  - DONE: valid_o=1 for one cycle -> IDLE.
  - ERR: err_o=1 for one cycle -> IDLE.
  - On entry to DONE or ERR, len_o<=cnt. len_o and err_code_o hold until the next SOF is accepted in IDLE.
- Output decoding:
  - start_o, valid_o, err_o are Moore decodes of state.
  - payload_o=data_r. payload_valid_o is combinational from state and data_r.
- Latency (in_valid=1 throughout):
  - SOF on data_i in cycle 0 -> start_o=1 from cycle 2.
  - Payload sample in cycle k -> payload_valid_o in cycle k+1.
  - EOF in cycle n -> valid_o pulse in cycle n+2; start_o=0 from cycle n+2.
- Boundaries:
  - SOF seen in DONE or ERR is ignored; the next SOF must arrive in IDLE.
  - EOF seen in IDLE is ignored.
  - cnt saturates and never wraps.
  - Reset mid-frame aborts silently: no err_o pulse.

Optional Feature:
PKG_DETECT_TIMEOUT_EN
- Defined: wdog counter and timeout abort (code 3) as above.
- Undefined: no wdog logic; PAYLOAD waits indefinitely on valid_r=0; err_code_o never equals 3; the TIMEOUT parameter is unused.

Decomposition:
- Package pkg_detect_pkg:
  - state enum: IDLE, PAYLOAD, DONE, ERR.
  - err_code constants: ERR_NONE, ERR_SHORT, ERR_OVF, ERR_TMO.
  - functions sof_marker(width) and eof_marker(width).
- One sub-module, pkg_watchdog: counter with clear, enable, and a terminal pulse at TIMEOUT-1. Instantiated only under PKG_DETECT_TIMEOUT_EN.

Test Plan:
- WIDTH=16: SOF 32'h7FFFFFFF, samples 1..5, EOF 32'h80000000 -> start_o high cycles 2..7, five payload_valid_o pulses, valid_o pulse at cycle 8, len_o=5, err_o=0.
- SOF, 2 samples, EOF with MIN_LEN=4 -> err_o pulse, err_code_o=1, len_o=2, valid_o stays 0.
- MAX_LEN=8: SOF and 9 samples -> 8 forwarded, 9th not forwarded; err_o pulse, err_code_o=2, len_o=8.
- TIMEOUT=16, macro defined: SOF, 1 sample, in_valid=0 for 16 cycles -> err_code_o=3 pulse. Macro undefined: start_o stays 1.
- SOF, 3 samples, SOF, 4 samples, EOF -> single valid_o pulse, len_o=4, no err_o.
- rst_n asserted asynchronously mid-payload -> all outputs 0 immediately; a subsequent SOF/4 samples/EOF frame completes with len_o=4.
